stream_demux_n: RTL and testbench



---
 rtl/stream_demux_n.sv | 141 ++++++++++++++
 tb/tb_stream_demux_n.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_n.sv
// stream_demux_n: 1-to-NUM_CH valid/ready stream demultiplexer with a single
// registered holding stage (one cycle of latency). The channel comes from in_sel
// (MODE=0) or from an internal round-robin pointer (MODE=1).
// Optional counters are enabled with the macro STREAM_DEMUX_CNT_EN.
// drop_cnt counts out-of-range drops and saturates at 0xFFFF.
// beat_cnt counts forwarded beats and wraps at 0xFFFF.
module stream_demux_n #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2,
   parameter int MODE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_sel,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              sel_err,
   output logic [SEL_W-1:0]  rr_ptr
`ifdef STREAM_DEMUX_CNT_EN
   ,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       beat_cnt
`endif
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   // One extra bit so the range check also works when 2^SEL_W == NUM_CH.
   localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W+1)'(NUM_CH);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [SEL_W-1:0]    ch_q, ch_d;
   logic [SEL_W-1:0]    rr_q, rr_d;
   logic                sel_err_q, sel_err_d;
   logic [SEL_W-1:0]    chan;
   logic                chan_ok;
   logic                fire;
   logic                accept;

   // Channel request: in round-robin mode the pointer is always in range, so no drops occur.
   assign chan    = (MODE == 1) ? rr_q : in_sel;
   assign chan_ok = ({1'b0, chan} < NUM_CH_X);
   assign accept  = in_valid && in_ready;

   // State register: a held beat is discarded immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_EMPTY;
      else     state_q <= state_d;
   end

   // Next state: a valid accept always refills the stage. Otherwise a fire empties it.
   // An out-of-range drop leaves the stage unchanged unless the held beat fires.
   always_comb begin
      state_d = state_q;
      if (accept && chan_ok) state_d = S_FULL;
      else if (fire)         state_d = S_EMPTY;
   end

   // Output decode: one-hot valid from the held channel.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_valid
         assign out_valid[gi] = (state_q == S_FULL) && (ch_q == SEL_W'(gi));
      end
   endgenerate

   // Handshake outputs: in_ready looks at out_ready so the stage refills on the same cycle it drains.
   always_comb begin
      fire     = |(out_valid & out_ready);
      in_ready = enable && ((state_q == S_EMPTY) || fire);
   end

   // Datapath next values: payload/channel capture, drop flag, round-robin advance.
   always_comb begin
      data_d    = data_q;
      ch_d      = ch_q;
      rr_d      = rr_q;
      sel_err_d = accept && !chan_ok;
      if (accept && chan_ok) begin
         data_d = in_data;
         ch_d   = chan;
      end
      if ((MODE == 1) && accept)
         rr_d = (rr_q == LAST_CH) ? '0 : rr_q + SEL_W'(1);
   end

   // Datapath registers: out_data holds its last value after the stage drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q    <= '0;
         ch_q      <= '0;
         rr_q      <= '0;
         sel_err_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         ch_q      <= ch_d;
         rr_q      <= rr_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign out_data = data_q;
   assign sel_err  = sel_err_q;
   assign rr_ptr   = rr_q;

`ifdef STREAM_DEMUX_CNT_EN
   logic [15:0] drop_q, drop_d;
   logic [15:0] beat_q, beat_d;

   // Counter next values: drops saturate, forwarded beats wrap.
   always_comb begin
      drop_d = drop_q;
      beat_d = beat_q;
      if (accept && !chan_ok && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
      if (fire)                                        beat_d = beat_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= '0;
         beat_q <= '0;
      end else begin
         drop_q <= drop_d;
         beat_q <= beat_d;
      end
   end

   assign drop_cnt = drop_q;
   assign beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_stream_demux_n.sv
// Testbench for stream_demux_n. It drives three instances from one shared input stream.
//   inst 0: NUM_CH=4, MODE=0
//   inst 1: NUM_CH=3, MODE=0 (in_sel=3 is out of range)
//   inst 2: NUM_CH=4, MODE=1 (round-robin)
// A behavioural holding-stage model predicts every output of every instance.
module tb_stream_demux_n;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [1:0] in_sel = 2'd0;
   logic [3:0] out_ready = 4'h0;

   logic [3:0] ov_a, ov_c;
   logic [2:0] ov_b;
   logic [7:0] od_a, od_b, od_c;
   logic       ir_a, ir_b, ir_c;
   logic       se_a, se_b, se_c;
   logic [1:0] rp_a, rp_b, rp_c;
`ifdef STREAM_DEMUX_CNT_EN
   logic [15:0] dc_a, dc_b, dc_c, bc_a, bc_b, bc_c;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stream_demux_n #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .MODE(0)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(ir_a),
      .in_data(in_data), .in_sel(in_sel), .out_valid(ov_a), .out_ready(out_ready),
      .out_data(od_a), .sel_err(se_a), .rr_ptr(rp_a)
`ifdef STREAM_DEMUX_CNT_EN
      , .drop_cnt(dc_a), .beat_cnt(bc_a)
`endif
   );

   stream_demux_n #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .MODE(0)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(ir_b),
      .in_data(in_data), .in_sel(in_sel), .out_valid(ov_b), .out_ready(out_ready[2:0]),
      .out_data(od_b), .sel_err(se_b), .rr_ptr(rp_b)
`ifdef STREAM_DEMUX_CNT_EN
      , .drop_cnt(dc_b), .beat_cnt(bc_b)
`endif
   );

   stream_demux_n #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .MODE(1)) dut_c (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(ir_c),
      .in_data(in_data), .in_sel(in_sel), .out_valid(ov_c), .out_ready(out_ready),
      .out_data(od_c), .sel_err(se_c), .rr_ptr(rp_c)
`ifdef STREAM_DEMUX_CNT_EN
      , .drop_cnt(dc_c), .beat_cnt(bc_c)
`endif
   );

   // Gather the outputs into arrays so the model loop can index them.
   logic [3:0] g_ov[3];
   logic [7:0] g_od[3];
   logic       g_ir[3];
   logic       g_se[3];
   logic [1:0] g_rp[3];
   assign g_ov[0] = ov_a;  assign g_ov[1] = {1'b0, ov_b};  assign g_ov[2] = ov_c;
   assign g_od[0] = od_a;  assign g_od[1] = od_b;          assign g_od[2] = od_c;
   assign g_ir[0] = ir_a;  assign g_ir[1] = ir_b;          assign g_ir[2] = ir_c;
   assign g_se[0] = se_a;  assign g_se[1] = se_b;          assign g_se[2] = se_c;
   assign g_rp[0] = rp_a;  assign g_rp[1] = rp_b;          assign g_rp[2] = rp_c;
`ifdef STREAM_DEMUX_CNT_EN
   logic [15:0] g_dc[3];
   logic [15:0] g_bc[3];
   assign g_dc[0] = dc_a;  assign g_dc[1] = dc_b;  assign g_dc[2] = dc_c;
   assign g_bc[0] = bc_a;  assign g_bc[1] = bc_b;  assign g_bc[2] = bc_c;
`endif

   // Model configuration and state, one entry per instance.
   int         nch[3] = '{4, 3, 4};
   int         rrmode[3] = '{0, 0, 1};
   bit         m_has[3];
   int         m_ch[3];
   logic [7:0] m_data[3];
   int         m_rr[3];
   bit         m_err[3];
   int         m_drop[3];
   int         m_beat[3];

   task automatic check(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s inst%0d t=%0t got=%0h exp=%0h", tag, inst, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_has[i] = 1'b0; m_ch[i] = 0; m_data[i] = 8'h00; m_rr[i] = 0;
         m_err[i] = 1'b0; m_drop[i] = 0; m_beat[i] = 0;
      end
   endtask

   // Compare all outputs with the model for the current inputs. Then advance the model by one clock.
   task automatic check_and_step();
      logic [3:0] exp_v;
      bit fire, rdy, acc;
      int chan;
      for (int i = 0; i < 3; i++) begin
         exp_v = m_has[i] ? 4'(1 << m_ch[i]) : 4'h0;
         fire  = m_has[i] && out_ready[m_ch[i]];
         rdy   = enable && (!m_has[i] || fire);
         check("out_valid", i, 32'(g_ov[i]), 32'(exp_v));
         check("out_data",  i, 32'(g_od[i]), 32'(m_data[i]));
         check("in_ready",  i, 32'(g_ir[i]), 32'(rdy));
         check("sel_err",   i, 32'(g_se[i]), 32'(m_err[i]));
         check("rr_ptr",    i, 32'(g_rp[i]), 32'(m_rr[i]));
`ifdef STREAM_DEMUX_CNT_EN
         check("drop_cnt",  i, 32'(g_dc[i]), 32'(m_drop[i]));
         check("beat_cnt",  i, 32'(g_bc[i]), 32'(m_beat[i]));
`endif
         acc  = in_valid && rdy;
         chan = (rrmode[i] == 1) ? m_rr[i] : int'(in_sel);
         m_err[i] = acc && (chan >= nch[i]);
         if (acc && chan < nch[i]) begin
            m_has[i] = 1'b1; m_ch[i] = chan; m_data[i] = in_data;
         end else if (fire) begin
            m_has[i] = 1'b0;
         end
         if (acc && chan >= nch[i] && m_drop[i] < 65535) m_drop[i]++;
         if (fire) m_beat[i] = (m_beat[i] + 1) % 65536;
         if (rrmode[i] == 1 && acc) m_rr[i] = (m_rr[i] + 1) % nch[i];
      end
   endtask

   // One clock: inputs are driven just after posedge and checked at the following negedge.
   task automatic cycle(input logic en, input logic v, input logic [7:0] d,
                        input logic [1:0] s, input logic [3:0] r);
      enable = en; in_valid = v; in_data = d; in_sel = s; out_ready = r;
      @(negedge clk);
      check_and_step();
      @(posedge clk);
      #1;
   endtask

   // Assert reset between edges and check that the outputs clear before any clock edge.
   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rst_valid", i, 32'(g_ov[i]), 32'h0);
         check("rst_data",  i, 32'(g_od[i]), 32'h0);
         check("rst_err",   i, 32'(g_se[i]), 32'h0);
         check("rst_rr",    i, 32'(g_rp[i]), 32'h0);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("por_valid", i, 32'(g_ov[i]), 32'h0);
         check("por_data",  i, 32'(g_od[i]), 32'h0);
      end
      rst = 1'b0;

      // Routing: 0x11..0x44 to sel 0..3 with every consumer ready.
      cycle(1, 1, 8'h11, 2'd0, 4'hF);
      cycle(1, 1, 8'h22, 2'd1, 4'hF);
      cycle(1, 1, 8'h33, 2'd2, 4'hF);
      cycle(1, 1, 8'h44, 2'd3, 4'hF);
      cycle(1, 0, 8'h00, 2'd0, 4'hF);
      cycle(1, 0, 8'h00, 2'd0, 4'hF);

      // Backpressure: ch1 is held for three cycles, then the stage fires and refills in the same cycle.
      cycle(1, 1, 8'h5A, 2'd1, 4'hF);
      repeat (3) cycle(1, 1, 8'h66, 2'd2, 4'b1101);
      check("bp_hold_valid", 0, 32'(g_ov[0]), 32'h2);
      check("bp_hold_data",  0, 32'(g_od[0]), 32'h5A);
      cycle(1, 1, 8'h66, 2'd2, 4'hF);
      cycle(1, 0, 8'h00, 2'd0, 4'hF);

      // Out-of-range select on the 3-channel instance.
      cycle(1, 1, 8'h77, 2'd3, 4'hF);
      check("oor_err", 1, 32'(g_se[1]), 32'h1);
      cycle(1, 0, 8'h00, 2'd0, 4'hF);
      cycle(1, 0, 8'h00, 2'd0, 4'hF);

      // Round-robin: six accepts from a fresh pointer end at 2. Then enable is held low.
      async_reset();
      repeat (6) cycle(1, 1, 8'($urandom), 2'd0, 4'hF);
      check("rr_end", 2, 32'(g_rp[2]), 32'h2);
      repeat (3) cycle(0, 1, 8'($urandom), 2'd0, 4'hF);
      check("rr_stall", 2, 32'(g_rp[2]), 32'h2);

      // Enable drops while the stage is full: the beat still drains.
      cycle(1, 1, 8'hAB, 2'd2, 4'h0);
      cycle(0, 1, 8'hCD, 2'd1, 4'hF);
      cycle(0, 1, 8'hCD, 2'd1, 4'hF);
      check("en_drained", 0, 32'(g_ov[0]), 32'h0);

      // Reset mid-transfer while holding 0xA5 on ch2.
      cycle(1, 1, 8'hA5, 2'd2, 4'h0);
      cycle(0, 0, 8'h00, 2'd0, 4'h0);
      check("pre_rst_valid", 0, 32'(g_ov[0]), 32'h4);
      check("pre_rst_data",  0, 32'(g_od[0]), 32'hA5);
      async_reset();
      cycle(1, 0, 8'h00, 2'd0, 4'h0);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 8'($urandom),
               2'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF & 4'($urandom | $urandom));
         if ($urandom_range(0, 199) == 0) async_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
